next_state_sequencer: RTL and testbench
=======================================

NEXT_STATE_SEQUENCER -- requirements
Module: next_state_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port ENC_STATE, input, 8, entry state from the load/store mode encoder (values 16,17,19,21,22,23,30,31).
REQ-004 SHALL have port MS_SEL, input, 3, next-address select from the current microinstruction.
REQ-005 SHALL have port MS_TARGET, input, 8, branch/call target from the current microinstruction.
REQ-006 SHALL have port COND, input, 1, condition for a conditional branch.
REQ-007 SHALL have port MOC, input, 1, memory operation complete.
REQ-008 SHALL have port LIST_LOAD, input, 1, load the register list from IR_LIST.
REQ-009 SHALL have port LIST_NEXT, input, 1, retire the lowest register in the list.
REQ-010 SHALL have port IR_LIST, input, 16, register-list field IR[15:0] for load/store multiple.
REQ-011 SHALL have port STATE, output, 8, current control state (registered).
REQ-012 SHALL have port REG_IDX, output, 4, index of the lowest set bit of the list register (0 if empty).
REQ-013 SHALL have port LIST_EMPTY, output, 1, high when the list register is zero.
REQ-014 SHALL have port WAIT_MOC, output, 1, high when MS_SEL=WAIT and MOC=0 (combinational).

Function
REQ-015 SHALL compute the next STATE from MS_SEL: 000 ENCODER -> ENC_STATE; 001 INC -> STATE+1; 010 JUMP -> MS_TARGET; 011 CJUMP -> MS_TARGET if COND else STATE+1.
REQ-016 SHALL continue the decode: 100 FETCH -> 8'd1; 101 WAIT -> STATE if MOC=0 else STATE+1; 110 CALL -> MS_TARGET, RET<=STATE+1; 111 RETURN -> RET.
REQ-017 SHALL hold one 8-bit return register RET, written only by CALL; a nested CALL overwrites it (single level).
REQ-018 SHALL perform all STATE+1 arithmetic modulo 256 (255 -> 0).
REQ-019 SHALL update STATE every cycle with a latency of one clock from its inputs; no stall exists other than WAIT.
REQ-020 SHALL hold a 16-bit list register: LIST_LOAD loads IR_LIST; else LIST_NEXT clears its lowest set bit; else it holds.
REQ-021 SHALL give LIST_LOAD priority when LIST_LOAD and LIST_NEXT are asserted in the same cycle.
REQ-022 SHALL leave the list unchanged when LIST_NEXT is asserted with the list empty.
REQ-023 SHALL drive REG_IDX and LIST_EMPTY combinationally from the list register, not from IR_LIST.
REQ-024 SHALL accept ENC_STATE unchecked; out-of-range values are the microcode's responsibility.

Reset
REQ-025 SHALL force STATE=8'd0, RET=8'd0 and list=16'h0000 asynchronously while RESET=1, giving REG_IDX=0 and LIST_EMPTY=1.
REQ-026 SHALL discard any in-progress WAIT, CALL or list walk when RESET asserts mid-operation.
REQ-027 SHALL leave state 0 on the first rising CLK after RESET deasserts, per the MS_SEL then presented.

Structure
REQ-028 SHALL take the MS_SEL encodings, RESET_STATE=8'd0 and FETCH_STATE=8'd1 from the shared control package.
REQ-029 SHALL implement lowest-set-bit detection as sub-module lowest_set_bit16 (16-bit in; 4-bit index and zero-flag out).

Verification
REQ-030 SHALL cover: RESET pulse mid-WAIT with STATE=45 -> STATE=0, RET=0, LIST_EMPTY=1 immediately; STATE=0 after release.
REQ-031 SHALL cover: MS_SEL=ENCODER, ENC_STATE=19 -> STATE=19 next cycle; then INC from 255 -> STATE=0.
REQ-032 SHALL cover: WAIT at STATE=20 with MOC low 3 cycles then high -> STATE stays 20 for 3 cycles, WAIT_MOC=1, then STATE=21.
REQ-033 SHALL cover: CALL MS_TARGET=100 at STATE=40 -> STATE=100, RET=41; later RETURN -> STATE=41.
REQ-034 SHALL cover: LIST_LOAD IR_LIST=16'h8011 then LIST_NEXT x3 -> REG_IDX 0,4,15, then LIST_EMPTY=1; a 4th LIST_NEXT leaves the list at 0.
REQ-035 SHALL cover: LIST_LOAD and LIST_NEXT together with IR_LIST=16'h0006 -> list=16'h0006, REG_IDX=1; CJUMP with COND=0 -> STATE+1.

Source files
------------

// File: rtl/next_state_sequencer_pkg.sv
// Shared control definitions for the microsequencer: next-address select codes
// and the fixed entry states.
package next_state_sequencer_pkg;

    typedef enum logic [2:0] {
        MsEncoder = 3'b000,
        MsInc     = 3'b001,
        MsJump    = 3'b010,
        MsCjump   = 3'b011,
        MsFetch   = 3'b100,
        MsWait    = 3'b101,
        MsCall    = 3'b110,
        MsReturn  = 3'b111
    } ms_sel_e;

    localparam logic [7:0] RESET_STATE = 8'd0;
    localparam logic [7:0] FETCH_STATE = 8'd1;

endpackage

// File: rtl/next_state_sequencer_lowest_set_bit16.sv
// Priority encoder: index of the lowest set bit of a 16-bit vector, plus a
// zero flag. The index reads 0 when the vector is empty.
module lowest_set_bit16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        zero
);

    always_comb begin
        idx = 4'd0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign zero = ~|vec;

endmodule

// File: rtl/next_state_sequencer.sv
// Microprogram next-state sequencer with a single-level return register and a
// register-list walker for load/store multiple.
module next_state_sequencer
    import next_state_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  ENC_STATE,
    input  logic [2:0]  MS_SEL,
    input  logic [7:0]  MS_TARGET,
    input  logic        COND,
    input  logic        MOC,
    input  logic        LIST_LOAD,
    input  logic        LIST_NEXT,
    input  logic [15:0] IR_LIST,
    output logic [7:0]  STATE,
    output logic [3:0]  REG_IDX,
    output logic        LIST_EMPTY,
    output logic        WAIT_MOC
);

    logic [7:0]  state_q, state_d;
    logic [7:0]  ret_q, ret_d;
    logic [7:0]  state_inc;
    logic [15:0] list_q, list_d;

    assign state_inc = state_q + 8'd1;

    always_comb begin
        state_d = state_inc;
        ret_d   = ret_q;
        unique case (ms_sel_e'(MS_SEL))
            MsEncoder: state_d = ENC_STATE;
            MsInc:     state_d = state_inc;
            MsJump:    state_d = MS_TARGET;
            MsCjump:   state_d = COND ? MS_TARGET : state_inc;
            MsFetch:   state_d = FETCH_STATE;
            MsWait:    state_d = MOC ? state_inc : state_q;
            MsCall: begin
                state_d = MS_TARGET;
                ret_d   = state_inc;
            end
            MsReturn:  state_d = ret_q;
            default:   state_d = state_inc;
        endcase
    end

    // Clearing the lowest set bit leaves an empty list at zero.
    always_comb begin
        list_d = list_q;
        if (LIST_LOAD) begin
            list_d = IR_LIST;
        end else if (LIST_NEXT) begin
            list_d = list_q & (list_q - 16'd1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= RESET_STATE;
            ret_q   <= RESET_STATE;
            list_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            list_q  <= list_d;
        end
    end

    lowest_set_bit16 u_lowest_set_bit16 (
        .vec  (list_q),
        .idx  (REG_IDX),
        .zero (LIST_EMPTY)
    );

    assign STATE    = state_q;
    assign WAIT_MOC = (MS_SEL == MsWait) && !MOC;

endmodule

// File: tb/tb_next_state_sequencer.sv
// Self-checking bench for next_state_sequencer: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_next_state_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  ENC_STATE = 8'd0;
    logic [2:0]  MS_SEL = 3'd1;
    logic [7:0]  MS_TARGET = 8'd0;
    logic        COND = 1'b0;
    logic        MOC = 1'b0;
    logic        LIST_LOAD = 1'b0;
    logic        LIST_NEXT = 1'b0;
    logic [15:0] IR_LIST = 16'h0000;
    logic [7:0]  STATE;
    logic [3:0]  REG_IDX;
    logic        LIST_EMPTY;
    logic        WAIT_MOC;

    int tests = 0;
    int fails = 0;

    int m_state = 0;
    int m_ret = 0;
    int m_list = 0;

    next_state_sequencer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENC_STATE  (ENC_STATE),
        .MS_SEL     (MS_SEL),
        .MS_TARGET  (MS_TARGET),
        .COND       (COND),
        .MOC        (MOC),
        .LIST_LOAD  (LIST_LOAD),
        .LIST_NEXT  (LIST_NEXT),
        .IR_LIST    (IR_LIST),
        .STATE      (STATE),
        .REG_IDX    (REG_IDX),
        .LIST_EMPTY (LIST_EMPTY),
        .WAIT_MOC   (WAIT_MOC)
    );

    always #5 CLK = ~CLK;

    function automatic int lowest_idx(input int v);
        for (int i = 0; i < 16; i++) begin
            if (((v >> i) & 1) == 1) return i;
        end
        return 0;
    endfunction

    // Reference model, written directly from the next-address rules.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_state <= 0;
            m_ret   <= 0;
            m_list  <= 0;
        end else begin
            int inc;
            inc = (m_state + 1) % 256;
            case (int'(MS_SEL))
                0: m_state <= int'(ENC_STATE);
                1: m_state <= inc;
                2: m_state <= int'(MS_TARGET);
                3: m_state <= COND ? int'(MS_TARGET) : inc;
                4: m_state <= 1;
                5: m_state <= MOC ? inc : m_state;
                6: begin
                    m_state <= int'(MS_TARGET);
                    m_ret   <= inc;
                end
                default: m_state <= m_ret;
            endcase
            if (LIST_LOAD) m_list <= int'(IR_LIST);
            else if (LIST_NEXT && m_list != 0) m_list <= m_list - (1 << lowest_idx(m_list));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle with inputs stable.
    always @(negedge CLK) begin
        chk("model_state", int'(STATE), m_state);
        chk("model_reg_idx", int'(REG_IDX), lowest_idx(m_list));
        chk("model_list_empty", int'(LIST_EMPTY), (m_list == 0) ? 1 : 0);
        chk("model_wait_moc", int'(WAIT_MOC), (MS_SEL == 3'd5 && !MOC) ? 1 : 0);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sel(input int s, input int target);
        MS_SEL = 3'(s);
        MS_TARGET = 8'(target);
        LIST_LOAD = 1'b0;
        LIST_NEXT = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        #1;
        chk("reset_state", int'(STATE), 0);
        chk("reset_reg_idx", int'(REG_IDX), 0);
        chk("reset_list_empty", int'(LIST_EMPTY), 1);
        repeat (2) tick();
        RESET = 1'b0;

        // Leave state 0 per the MS_SEL presented.
        sel(1, 0); tick();
        chk("post_reset_inc", int'(STATE), 1);

        ENC_STATE = 8'd19; sel(0, 0); tick();
        chk("encoder_19", int'(STATE), 19);
        sel(2, 255); tick();
        chk("jump_255", int'(STATE), 255);
        sel(1, 0); tick();
        chk("inc_wrap", int'(STATE), 0);

        sel(2, 20); tick();
        sel(5, 0); MOC = 1'b0; #1;
        chk("wait_moc_high", int'(WAIT_MOC), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_hold", int'(STATE), 20);
            chk("wait_moc_hold", int'(WAIT_MOC), 1);
        end
        MOC = 1'b1; #1;
        chk("wait_moc_low", int'(WAIT_MOC), 0);
        tick();
        chk("wait_release", int'(STATE), 21);
        MOC = 1'b0;

        sel(2, 40); tick();
        sel(6, 100); tick();
        chk("call_target", int'(STATE), 100);
        sel(1, 0); tick();
        chk("after_call_inc", int'(STATE), 101);
        sel(7, 0); tick();
        chk("return_41", int'(STATE), 41);

        sel(1, 0); LIST_LOAD = 1'b1; IR_LIST = 16'h8011; tick();
        chk("list_load_idx", int'(REG_IDX), 0);
        chk("list_load_nonempty", int'(LIST_EMPTY), 0);
        LIST_LOAD = 1'b0; LIST_NEXT = 1'b1; tick();
        chk("list_next1", int'(REG_IDX), 4);
        tick();
        chk("list_next2", int'(REG_IDX), 15);
        tick();
        chk("list_next3_empty", int'(LIST_EMPTY), 1);
        chk("list_next3_idx", int'(REG_IDX), 0);
        tick();
        chk("list_next4_empty", int'(LIST_EMPTY), 1);

        LIST_LOAD = 1'b1; LIST_NEXT = 1'b1; IR_LIST = 16'h0006; tick();
        chk("load_priority_idx", int'(REG_IDX), 1);
        chk("load_priority_nonempty", int'(LIST_EMPTY), 0);
        LIST_LOAD = 1'b0; LIST_NEXT = 1'b0; IR_LIST = 16'hffff; #1;
        chk("idx_from_list_reg", int'(REG_IDX), 1);

        sel(2, 70); tick();
        sel(3, 5); COND = 1'b0; tick();
        chk("cjump_not_taken", int'(STATE), 71);
        COND = 1'b1; tick();
        chk("cjump_taken", int'(STATE), 5);
        COND = 1'b0;

        sel(4, 0); tick();
        chk("fetch", int'(STATE), 1);

        // Reset mid-WAIT at state 45 with RET and list populated.
        sel(2, 44); tick();
        sel(6, 45); LIST_LOAD = 1'b1; IR_LIST = 16'h0100; tick();
        chk("pre_reset_state", int'(STATE), 45);
        sel(5, 0); MOC = 1'b0; tick();
        chk("mid_wait_state", int'(STATE), 45);
        #1 RESET = 1'b1;
        #1;
        chk("async_reset_state", int'(STATE), 0);
        chk("async_reset_empty", int'(LIST_EMPTY), 1);
        tick();
        chk("held_reset_state", int'(STATE), 0);
        RESET = 1'b0;
        sel(7, 0); tick();
        chk("ret_cleared", int'(STATE), 0);

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            MS_SEL    = 3'($urandom_range(0, 7));
            MS_TARGET = 8'($urandom);
            ENC_STATE = 8'($urandom);
            COND      = 1'($urandom);
            MOC       = ($urandom_range(0, 3) != 0);
            LIST_LOAD = ($urandom_range(0, 5) == 0);
            LIST_NEXT = ($urandom_range(0, 1) == 0);
            IR_LIST   = 16'($urandom);
            RESET     = ($urandom_range(0, 199) == 0);
            tick();
            RESET = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
